// File: rtl/seg_pkg.sv
// seg_pkg: shared scanner state encoding and the all-off digit select pattern.
package seg_pkg;
  typedef enum logic {GUARD, SHOW} state_t;
  localparam logic [7:0] DIGIT_OFF = '1;
endpackage

// File: rtl/seg_lz_mask.sv
// seg_lz_mask: flags digits above digit 0 whose nibble and every higher nibble are zero.
module seg_lz_mask #(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] i_shadow,
  output logic [DIGITS-1:0]   o_mask
);
  logic w_zero;
  always_comb begin
    o_mask = '0;
    w_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      w_zero    = w_zero && (i_shadow[4*i +: 4] == 4'h0);
      o_mask[i] = w_zero;
    end
  end
endmodule

// File: rtl/seg_scan.sv
// seg_scan: multiplexed hex display scanner with per-slot dark guard and frame-synchronous commit.
// Define LZ_SUPPRESS_EN to darken leading-zero digits.
module seg_scan import seg_pkg::*; #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int DEAD   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] value,
  input  logic                load,
  input  logic [DIGITS-1:0]   blank_mask,
  output logic [3:0]          nibble,
  output logic [DIGITS-1:0]   digit_sel,
  output logic                blank,
  output logic                frame_done,
  output logic                pend
);
  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);
  state_t              r_state, w_nxt_state;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx, w_nxt_idx;
  logic [4*DIGITS-1:0] r_shadow, r_pending;
  logic [DIGITS-1:0]   w_lz, w_dark;
  logic                w_slot_end, w_commit, w_show;
`ifdef LZ_SUPPRESS_EN
  seg_lz_mask #(.DIGITS(DIGITS)) u_lz (.i_shadow(r_shadow), .o_mask(w_lz));
`else
  assign w_lz = '0;
`endif
  // idx only advances when leaving SHOW, so r_idx already names the digit of the next SHOW cycle
  always_comb begin
    w_slot_end  = (r_state == GUARD) ? (r_cnt == CW'(DEAD - 1)) : (r_cnt == CW'(DIV - DEAD - 1));
    w_nxt_state = w_slot_end ? ((r_state == GUARD) ? SHOW : GUARD) : r_state;
    w_commit    = w_slot_end && (r_state == SHOW) && (r_idx == IW'(DIGITS - 1));
    w_nxt_idx   = (w_slot_end && r_state == SHOW) ? (w_commit ? '0 : r_idx + IW'(1)) : r_idx;
    w_dark      = blank_mask | w_lz;
    w_show      = (w_nxt_state == SHOW) && !w_dark[r_idx];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= GUARD;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shadow   <= '0;
      r_pending  <= '0;
      pend       <= 1'b0;
      digit_sel  <= DIGIT_OFF[DIGITS-1:0];
      nibble     <= '0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_slot_end ? '0 : r_cnt + CW'(1);
      r_idx      <= w_nxt_idx;
      r_pending  <= load ? value : r_pending;
      pend       <= !w_commit && (load || pend);
      if (w_commit)
        r_shadow <= load ? value : (pend ? r_pending : r_shadow);
      frame_done <= w_commit;
      digit_sel  <= w_show ? ~(DIGITS'(1) << r_idx) : DIGIT_OFF[DIGITS-1:0];
      nibble     <= (w_nxt_state == SHOW) ? r_shadow[4*r_idx +: 4] : '0;
      blank      <= !w_show;
    end
  end
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed checks of scan timing, load/commit, blanking and async reset (DIGITS=4, DIV=8, DEAD=2).
module tb_seg_scan;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic [3:0]  blank_mask;
  logic [3:0]  nibble;
  logic [3:0]  digit_sel;
  logic        blank, frame_done, pend;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] exp_sh;
  logic [3:0]  exp_mask;
  logic        exp_pend;
`ifdef LZ_SUPPRESS_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  seg_scan #(.DIGITS(4), .DIV(8), .DEAD(2)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_mask(blank_mask),
    .nibble(nibble), .digit_sel(digit_sel), .blank(blank), .frame_done(frame_done), .pend(pend)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask
  function automatic logic lz_dark(input logic [15:0] sh, input int s);
    return LZ && s > 0 && ((sh >> (4 * s)) == 16'h0);
  endfunction
  task automatic check_cycle(input string ph, input int c);
    int          pos, slot;
    logic        show;
    logic [3:0]  es;
    logic [15:0] t;
    pos  = c % 32;
    slot = pos / 8;
    show = (pos % 8) >= 2 && !exp_mask[slot] && !lz_dark(exp_sh, slot);
    es   = 4'hF;
    if (show) es[slot] = 1'b0;
    t    = exp_sh >> (4 * slot);
    check($sformatf("%s sel@%0d", ph, c), 32'(digit_sel), 32'(es));
    check($sformatf("%s blank@%0d", ph, c), 32'(blank), 32'(!show));
    check($sformatf("%s done@%0d", ph, c), 32'(frame_done), 32'(pos == 0 && c > 0));
    check($sformatf("%s pend@%0d", ph, c), 32'(pend), 32'(exp_pend));
    if (show) check($sformatf("%s nib@%0d", ph, c), 32'(nibble), 32'(t[3:0]));
  endtask
  initial begin
    rst_n = 1'b0; load = 1'b0; value = '0; blank_mask = '0;
    exp_sh = '0; exp_mask = '0; exp_pend = 1'b0;
    #12;
    check("rst sel", 32'(digit_sel), 32'hF);
    check("rst blank", 32'(blank), 32'd1);
    check("rst nib", 32'(nibble), 32'd0);
    check("rst done", 32'(frame_done), 32'd0);
    check("rst pend", 32'(pend), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c <= 147; c++) begin
      exp_sh   = (c < 32) ? 16'h0000 : (c < 64) ? 16'h12A5 : 16'hBEEF;
      exp_pend = (c >= 6 && c < 32);
      exp_mask = (c >= 96 && c <= 128) ? 4'b0010 : 4'b0000;
      check_cycle("A", c);
      if (c == 147) break;
      load = (c == 5 || c == 63);
      value = (c == 5) ? 16'h12A5 : (c == 63) ? 16'hBEEF : 16'h3333;
      if (c == 95) blank_mask = 4'b0010;
      if (c == 128) blank_mask = 4'b0000;
      @(negedge clk);
    end
    #1 rst_n = 1'b0;
    #1;
    check("mid-rst sel", 32'(digit_sel), 32'hF);
    check("mid-rst blank", 32'(blank), 32'd1);
    check("mid-rst nib", 32'(nibble), 32'd0);
    check("mid-rst pend", 32'(pend), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c <= 64; c++) begin
      exp_sh   = (c < 32) ? 16'h0000 : 16'h0040;
      exp_pend = (c >= 6 && c < 32);
      exp_mask = 4'b0000;
      check_cycle("B", c);
      load  = (c == 5);
      value = (c == 5) ? 16'h0040 : 16'h0000;
      @(negedge clk);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 SHALL have parameter DIV, default 50000, clocks per digit slot (legal 4..2^20).
REQ-003 SHALL have parameter DEAD, default 16, all-off guard clocks at the start of each slot (legal 1..DIV-2).
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port value  in  4*DIGITS  hex value to display; nibble i feeds digit i, digit 0 rightmost.
REQ-007 SHALL have port load  in  1  one-cycle strobe capturing value into the pending register.
REQ-008 SHALL have port blank_mask  in  DIGITS  bit i high forces digit i dark.
REQ-009 SHALL have port nibble  out  4  current digit code to the downstream seven-segment decoder.
REQ-010 SHALL have port digit_sel  out  DIGITS  active-low one-hot digit enable; all-ones means all off.
REQ-011 SHALL have port blank  out  1  high when no digit is lit this cycle.
REQ-012 SHALL have port frame_done  out  1  one-cycle pulse on frame commit.
REQ-013 SHALL have port pend  out  1  high while a loaded value awaits commit.

Function
REQ-014 SHALL implement two states, GUARD and SHOW, with slot counter cnt and digit index idx.
REQ-015 GUARD SHALL last DEAD cycles with digit_sel all-ones and blank=1, then transition to SHOW with cnt=0.
REQ-016 SHOW SHALL last DIV-DEAD cycles with digit_sel[idx]=0 (unless blanked), nibble=shadow nibble idx, blank=0, then transition to GUARD.
REQ-017 On SHOW->GUARD, idx SHALL increment, wrapping DIGITS-1 to 0.
REQ-018 On the idx wrap edge (commit), shadow SHALL take pending if pend=1, pend SHALL clear, and frame_done SHALL pulse for exactly one cycle.
REQ-019 load SHALL copy value to pending and set pend; multiple loads before commit: last wins.
REQ-020 load coincident with the commit edge SHALL commit that cycle's value directly into shadow and leave pend=0.
REQ-021 A digit with blank_mask[i]=1 SHALL keep digit_sel all-ones and blank=1 for its SHOW slot; slot timing is unchanged.
REQ-022 All outputs SHALL be registered and change on the same edge as the state transition that causes them.
REQ-023 blank_mask SHALL be sampled every cycle (no commit delay).

Reset
REQ-024 rst_n low SHALL immediately force: state GUARD, cnt=0, idx=0, shadow=0, pending=0, pend=0, digit_sel all-ones, nibble=0, blank=1, frame_done=0.
REQ-025 Reset asserted mid-slot SHALL abandon the slot; after release, operation restarts with GUARD of digit 0.

Configuration
REQ-026 With LZ_SUPPRESS_EN defined, digit i>0 SHALL be dark (as REQ-021) when shadow nibbles i..DIGITS-1 are all zero; digit 0 is never suppressed.
REQ-027 Without LZ_SUPPRESS_EN, leading zeros SHALL display as "0"; only blank_mask darkens digits.

Structure
REQ-028 Package seg_pkg SHALL hold the state enum (GUARD, SHOW) and constant DIGIT_OFF (all-ones select pattern).
REQ-029 Leading-zero mask logic SHALL be a combinational sub-module seg_lz_mask, instantiated only under LZ_SUPPRESS_EN.
REQ-030 Counter widths SHALL be derived from DIV and DIGITS via $clog2; no fixed widths.

Verification (DIGITS=4, DIV=8, DEAD=2)
REQ-031 Release reset -> digit_sel 1111 x2, 1110 x6, 1111 x2, 1101 x6, ... 0111 x6; frame_done high on cycle 32 only.
REQ-032 load value=16'h12A5 at cycle 5 -> pend=1, nibble stays 0 until commit; next frame nibble 5,A,2,1 on digits 0..3, pend=0.
REQ-033 load 16'hBEEF on the commit edge -> shadow=16'hBEEF that edge, pend stays 0, next frame shows F,E,E,B.
REQ-034 LZ_SUPPRESS_EN, shadow 16'h0040 -> digits 3,2 dark (blank=1), digit 1 shows 4, digit 0 shows 0; shadow 16'h0000 -> only digit 0 lit showing 0.
REQ-035 blank_mask=4'b0010 -> digit 1 slot keeps 1111, blank=1; other digits unaffected; frame length still 32.
REQ-036 rst_n low during SHOW of digit 2 -> digit_sel=1111, blank=1 without a clock edge; after release, sequence restarts per REQ-031.
